// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the processor front end: instruction opcodes, the
// instruction-register field positions, the fetch sequencer state type and a
// small helper to pull the opcode out of an instruction word.
// -----------------------------------------------------------------------------
package proc_pkg;

    // Opcodes (instruction bits [8:6])
    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Instruction field slice positions: III XXX YYY
    localparam int OPC_HI = 8;
    localparam int OPC_LO = 6;
    localparam int X_HI   = 5;
    localparam int X_LO   = 3;
    localparam int Y_HI   = 2;
    localparam int Y_LO   = 0;

    // Fetch sequencer states; S_STEP_WAIT is only reachable in the
    // single-step build.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_WAIT_I    = 4'd2,
        S_DECODE    = 4'd3,
        S_FETCH_IMM = 4'd4,
        S_WAIT_IMM  = 4'd5,
        S_EXEC      = 4'd6,
        S_NEXT      = 4'd7,
        S_HALT      = 4'd8,
        S_STEP_WAIT = 4'd9
    } fetch_state_e;

    // Opcode field of a 9-bit instruction word
    function automatic logic [2:0] opcode_of(input logic [8:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// -----------------------------------------------------------------------------
// fetch_pc
// Program counter for the instruction fetch sequencer. Advances by one for a
// normal instruction and by two for MVI (skipping the immediate word). All
// arithmetic wraps modulo 2^ADDR_W.
//
// Ports:
//   clock       in   system clock (rising edge)
//   resetn      in   synchronous active-low reset, clears the PC
//   adv_i       in   advance the PC this cycle
//   skip_imm_i  in   when advancing, step over an immediate word (+2)
//   pc_o        out  current PC
//   pc_plus1_o  out  PC + 1 (address of an MVI immediate), wrapped
// -----------------------------------------------------------------------------
module fetch_pc #(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              adv_i,
    input  logic              skip_imm_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus1_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC: hold, +1, or +2 for MVI; natural wrap of the ADDR_W-bit sum
    always_comb begin
        pc_d = pc_q;
        if (adv_i) begin
            if (skip_imm_i) begin
                pc_d = pc_q + ADDR_W'(2);
            end else begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register with synchronous reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus1_o = pc_q + ADDR_W'(1);

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Upstream sequencer for the processor control unit. Fetches 9-bit
// instructions from a synchronous instruction memory, holds them on ir,
// pre-fetches the MVI immediate onto din, raises run until the control unit
// answers with done, then advances the PC. Opcode 111 halts the sequencer
// until reset.
//
// Build option: define INSTR_FETCH_STEP_EN to add a 'step' input; after each
// instruction the sequencer then waits for a cycle with step=1 and start=1
// before fetching the next one (one instruction per step pulse).
//
// Ports:
//   clock     in   system clock (rising edge)
//   resetn    in   synchronous active-low reset
//   start     in   level; fetch/continue while high
//   step      in   single-step advance (INSTR_FETCH_STEP_EN builds only)
//   mem_addr  out  instruction memory address
//   mem_rd    out  one-cycle read strobe per request
//   mem_q     in   read data, valid MEM_LAT cycles after mem_rd
//   done      in   one-cycle completion pulse from the control unit
//   ir        out  current instruction
//   din       out  immediate word for MVI
//   run       out  execute request to the control unit
//   pc        out  address of the instruction in ir
//   halted    out  set once a HALT instruction has been decoded
// -----------------------------------------------------------------------------
module instr_fetch
    import proc_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 9,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
`ifdef INSTR_FETCH_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              done,
    output logic [8:0]        ir,
    output logic [DATA_W-1:0] din,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    // Index of the WAIT cycle in which read data is valid
    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic [8:0]        ir_q;
    logic [DATA_W-1:0] din_q;
    logic              run_q;
    logic              halted_q;
    logic [1:0]        wait_cnt_q;

    logic [ADDR_W-1:0] pc_s;
    logic [ADDR_W-1:0] pc_plus1_s;
    logic              adv_s;
    logic              skip_imm_s;

    // The PC advances on the edge that accepts done, so it already points
    // at the next instruction while the sequencer sits in NEXT. ir is
    // stable throughout EXEC, so its opcode selects the +2 step for MVI.
    assign adv_s      = (state_q == S_EXEC) && done;
    assign skip_imm_s = (opcode_of(ir_q) == OP_MVI);

    fetch_pc #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clock      (clock),
        .resetn     (resetn),
        .adv_i      (adv_s),
        .skip_imm_i (skip_imm_s),
        .pc_o       (pc_s),
        .pc_plus1_o (pc_plus1_s)
    );

    // Fetch sequencer FSM with registered outputs. mem_rd defaults low so
    // every read strobe lasts exactly the one cycle of FETCH/FETCH_IMM.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            ir_q       <= 9'd0;
            din_q      <= '0;
            run_q      <= 1'b0;
            halted_q   <= 1'b0;
            wait_cnt_q <= 2'd0;
        end else begin
            mem_rd_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_FETCH;
                        mem_addr_q <= pc_s;
                        mem_rd_q   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state_q    <= S_WAIT_I;
                    wait_cnt_q <= 2'd0;
                end
                S_WAIT_I: begin
                    if (wait_cnt_q == LAT_LAST) begin
                        ir_q    <= mem_q[8:0];
                        state_q <= S_DECODE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                S_DECODE: begin
                    case (opcode_of(ir_q))
                        OP_HALT: begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end
                        OP_MVI: begin
                            state_q    <= S_FETCH_IMM;
                            mem_addr_q <= pc_plus1_s;
                            mem_rd_q   <= 1'b1;
                        end
                        default: begin
                            state_q <= S_EXEC;
                            run_q   <= 1'b1;
                        end
                    endcase
                end
                S_FETCH_IMM: begin
                    state_q    <= S_WAIT_IMM;
                    wait_cnt_q <= 2'd0;
                end
                S_WAIT_IMM: begin
                    if (wait_cnt_q == LAT_LAST) begin
                        din_q   <= mem_q;
                        state_q <= S_EXEC;
                        run_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                S_EXEC: begin
                    if (done) begin
                        run_q   <= 1'b0;
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (start) begin
`ifdef INSTR_FETCH_STEP_EN
                        state_q <= S_STEP_WAIT;
`else
                        state_q    <= S_FETCH;
                        mem_addr_q <= pc_s;
                        mem_rd_q   <= 1'b1;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
`ifdef INSTR_FETCH_STEP_EN
                S_STEP_WAIT: begin
                    if (step && start) begin
                        state_q    <= S_FETCH;
                        mem_addr_q <= pc_s;
                        mem_rd_q   <= 1'b1;
                    end
                end
`endif
                S_HALT: begin
                    // Only reset leaves HALT
                    run_q    <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign ir       = ir_q;
    assign din      = din_q;
    assign run      = run_q;
    assign pc       = pc_s;
    assign halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch (default build, MEM_LAT = 1). The bench
// owns a 32-word synchronous memory and a program-level reference model: the
// model PC walks the program, expects ir = mem[pc], din = mem[pc+1] for MVI,
// run after 2+MEM_LAT (or 3+2*MEM_LAT for MVI) cycles, and pc + 1/+2 mod 32.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int AW  = 5;
    localparam int DW  = 9;
    localparam int LAT = 1;

    localparam logic [2:0] T_MVI  = 3'b001;
    localparam logic [2:0] T_HALT = 3'b111;

    logic          clock;
    logic          resetn;
    logic          start;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_q;
    logic          done;
    logic [8:0]    ir;
    logic [DW-1:0] din;
    logic          run;
    logic [AW-1:0] pc;
    logic          halted;

    logic [8:0]    mem [0:31];
    logic [AW-1:0] model_pc;
    logic [DW-1:0] model_din;
    int            n_checks;
    int            n_pass;

    instr_fetch #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MEM_LAT (LAT)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_q    (mem_q),
        .done     (done),
        .ir       (ir),
        .din      (din),
        .run      (run),
        .pc       (pc),
        .halted   (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous instruction memory, one cycle latency
    always @(posedge clock) begin
        if (mem_rd === 1'b1) mem_q <= mem[mem_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [2:0] rand_op(input bit allow_mvi);
        logic [2:0] op;
        op = 3'($urandom_range(0, 6));
        if (!allow_mvi && op == T_MVI) op = 3'b010;
        return op;
    endfunction

    task automatic load_random(input bit allow_mvi);
        for (int i = 0; i < 32; i++) mem[i] = {rand_op(allow_mvi), 6'($urandom)};
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        start  = 1'b0;
        done   = 1'b0;
        tick();
        tick();
        resetn    = 1'b1;
        model_pc  = 5'd0;
        model_din = 9'd0;
    endtask

    // Execute one instruction against the model: fetch address, latency,
    // ir/din/pc at run, run held for 'hold' cycles, PC after done.
    task automatic run_instr(input int hold, input bit drop_start);
        int         n;
        int         lat;
        logic [8:0] exp_ir;
        bit         is_mvi;
        int         exp_lat;
        logic [AW-1:0] next_pc;
        n = 0;
        while (mem_rd !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++;
        if (n >= 20) begin
            $display("FAIL fetch_timeout: mem_rd not seen, pc model %0d", model_pc);
            return;
        end else n_pass++;
        n_checks++;
        if (mem_addr !== model_pc) $display("FAIL fetch_addr: got %0d expected %0d", mem_addr, model_pc);
        else n_pass++;
        exp_ir  = mem[model_pc];
        is_mvi  = (exp_ir[8:6] == T_MVI);
        exp_lat = is_mvi ? (3 + 2 * LAT) : (2 + LAT);
        next_pc = is_mvi ? model_pc + 5'd2 : model_pc + 5'd1;
        if (is_mvi) model_din = mem[model_pc + 5'd1];
        lat = 0;
        while (run !== 1'b1 && lat < 20) begin tick(); lat++; end
        n_checks++;
        if (lat !== exp_lat) $display("FAIL run_latency: got %0d expected %0d", lat, exp_lat);
        else n_pass++;
        n_checks++;
        if (ir !== exp_ir) $display("FAIL ir_at_run: got %09b expected %09b", ir, exp_ir);
        else n_pass++;
        n_checks++;
        if (din !== model_din) $display("FAIL din_at_run: got %0d expected %0d", din, model_din);
        else n_pass++;
        n_checks++;
        if (pc !== model_pc) $display("FAIL pc_at_run: got %0d expected %0d", pc, model_pc);
        else n_pass++;
        if (drop_start) start = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            n_checks++;
            if (run !== 1'b1 || ir !== exp_ir || din !== model_din)
                $display("FAIL exec_hold: cycle %0d run=%b ir=%09b din=%0d expected run=1 ir=%09b din=%0d",
                         i, run, ir, din, exp_ir, model_din);
            else n_pass++;
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (run !== 1'b0) $display("FAIL run_after_done: got %b expected 0", run);
        else n_pass++;
        n_checks++;
        if (pc !== next_pc) $display("FAIL pc_after_done: got %0d expected %0d", pc, next_pc);
        else n_pass++;
        model_pc = next_pc;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b1;
        done   = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({pc, mem_addr, mem_rd, run, halted} !== {5'd0, 5'd0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_ctrl: pc=%0d addr=%0d rd=%b run=%b halted=%b expected all 0",
                     pc, mem_addr, mem_rd, run, halted);
        else n_pass++;
        n_checks++;
        if (ir !== 9'd0 || din !== 9'd0) $display("FAIL reset_data: ir=%0d din=%0d expected 0", ir, din);
        else n_pass++;
        start = 1'b0;
    endtask

    task automatic test_basic_mv_mvi_stop();
        do_reset();
        load_random(1'b0);
        mem[0] = 9'b000001000;
        mem[1] = 9'b001000000;
        mem[2] = 9'd2;
        mem[3] = 9'b010000001;
        start = 1'b1;
        run_instr(0, 1'b0);     // done in first EXEC cycle
        run_instr(10, 1'b0);    // MVI with done held off 10 cycles
        run_instr(2, 1'b1);     // start dropped mid-instruction
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (mem_rd !== 1'b0 || run !== 1'b0 || pc !== 5'd4)
                $display("FAIL stop_idle: rd=%b run=%b pc=%0d expected 0 0 4", mem_rd, run, pc);
            else n_pass++;
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (mem_rd !== 1'b0 || run !== 1'b0 || pc !== 5'd4)
                $display("FAIL stray_done: rd=%b run=%b pc=%0d expected 0 0 4", mem_rd, run, pc);
            else n_pass++;
        end
        start = 1'b1;
        run_instr(0, 1'b1);
    endtask

    task automatic test_random_program();
        do_reset();
        load_random(1'b1);
        start = 1'b1;
        for (int k = 0; k < 25; k++) run_instr(int'($urandom_range(0, 4)), k == 24);
    endtask

    task automatic test_pc_wrap();
        do_reset();
        load_random(1'b0);
        mem[0]  = 9'd5;
        mem[31] = 9'b001011000;
        start = 1'b1;
        for (int k = 0; k < 32; k++) run_instr(int'($urandom_range(0, 3)), k == 31);
        n_checks++;
        if (din !== 9'd5 || pc !== 5'd1) $display("FAIL wrap_imm: din=%0d pc=%0d expected 5 1", din, pc);
        else n_pass++;
    endtask

    task automatic test_halt();
        int n;
        bit run_seen;
        bit rd_seen;
        do_reset();
        load_random(1'b0);
        mem[0] = 9'b010001010;
        mem[1] = 9'b111000000;
        start = 1'b1;
        run_instr(1, 1'b0);
        n = 0;
        while (mem_rd !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++;
        if (mem_addr !== 5'd1) $display("FAIL halt_fetch: addr=%0d expected 1", mem_addr);
        else n_pass++;
        run_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); if (run === 1'b1) run_seen = 1'b1; end
        n_checks++;
        if (halted !== 1'b1 || run_seen || ir !== 9'b111000000 || pc !== 5'd1)
            $display("FAIL halt_state: halted=%b run_seen=%b ir=%09b pc=%0d expected 1 0 111000000 1",
                     halted, run_seen, ir, pc);
        else n_pass++;
        rd_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); if (mem_rd !== 1'b0) rd_seen = 1'b1; end
        n_checks++;
        if (rd_seen) $display("FAIL halt_no_read: mem_rd=1 seen expected 0");
        else n_pass++;
        resetn = 1'b0;
        start  = 1'b0;
        tick();
        resetn = 1'b1;
        n_checks++;
        if (pc !== 5'd0 || halted !== 1'b0 || ir !== 9'd0)
            $display("FAIL halt_reset: pc=%0d halted=%b ir=%0d expected 0 0 0", pc, halted, ir);
        else n_pass++;
        rd_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); if (mem_rd !== 1'b0) rd_seen = 1'b1; end
        start = 1'b1;
        n = 0;
        while (mem_rd !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++;
        if (rd_seen || n != 1 || mem_addr !== 5'd0)
            $display("FAIL halt_restart: early_rd=%b wait=%0d addr=%0d expected 0 1 0", rd_seen, n, mem_addr);
        else n_pass++;
        start = 1'b0;
    endtask

    task automatic test_reset_in_wait_imm();
        int n;
        do_reset();
        load_random(1'b0);
        mem[0] = 9'b001010000;
        mem[1] = 9'($urandom_range(1, 511));
        start = 1'b1;
        n = 0;
        while (mem_rd !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
        n = 0;
        while (mem_rd !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++;
        if (mem_addr !== 5'd1) $display("FAIL imm_fetch_addr: got %0d expected 1", mem_addr);
        else n_pass++;
        tick();                 // now in WAIT_IMM with data on mem_q
        resetn = 1'b0;
        tick();
        n_checks++;
        if ({pc, mem_addr, mem_rd, run, halted} !== {5'd0, 5'd0, 1'b0, 1'b0, 1'b0} ||
            ir !== 9'd0 || din !== 9'd0)
            $display("FAIL reset_mid_op: pc=%0d addr=%0d rd=%b run=%b halted=%b ir=%0d din=%0d expected all 0",
                     pc, mem_addr, mem_rd, run, halted, ir, din);
        else n_pass++;
        resetn    = 1'b1;
        model_pc  = 5'd0;
        model_din = 9'd0;
        run_instr(1, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mem_q    = 9'd0;
        for (int i = 0; i < 32; i++) mem[i] = 9'd0;
        test_reset();
        test_basic_mv_mvi_stop();
        test_random_program();
        test_pc_wrap();
        test_halt();
        test_reset_in_wait_imm();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
